// File: rtl/switch_table_mc.sv
// switch_table_mc: multi-table jump-address lookup loaded over a ready/valid stream.
// Optional macro SWITCH_RELOAD_EN keeps the load port open in READY so the table can be restreamed.
`default_nettype none

module switch_table_mc #(
    parameter int ADR_BUS_WIDTH = 8,
    parameter int SEL_BITS      = 8,
    parameter int TABLE_BITS    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADR_BUS_WIDTH-1:0]       switch_tdata,
    input  logic                           switch_tvalid,
    input  logic                           switch_tlast,
    output logic                           switch_tready,
    input  logic [TABLE_BITS-1:0]          jadr,
    input  logic [SEL_BITS-1:0]            switch_offset_adr,
    input  logic                           switch_active,
    output logic                           ready,
    output logic [ADR_BUS_WIDTH-1:0]       switch_adr,
    output logic                           switch_adr_valid,
    output logic [TABLE_BITS+SEL_BITS:0]   load_count
);

    localparam int ADDR_W = TABLE_BITS + SEL_BITS;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          ptr;
    logic [ADDR_W:0]            count;
    logic [ADR_BUS_WIDTH-1:0]   adr_q;
    logic                       valid_q;
    logic [ADR_BUS_WIDTH-1:0]   mem [DEPTH];

    logic                       beat;
    logic [ADDR_W-1:0]          wr_adr;
    logic [ADDR_W-1:0]          rd_adr;

    // The reset term keeps the port closed during the reset cycle itself.
`ifdef SWITCH_RELOAD_EN
    assign switch_tready = ~rst;
`else
    assign switch_tready = ~rst & (state == ST_LOAD);
`endif

    assign beat   = switch_tvalid & switch_tready;
    assign rd_adr = {jadr, switch_offset_adr};

    always_comb begin
        wr_adr = ptr;
        if (state == ST_READY) begin
            wr_adr = '0;
        end
    end

    // Table storage has no reset: a short or aborted load leaves older entries intact.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_adr] <= switch_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_LOAD;
            ptr     <= '0;
            count   <= '0;
            adr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            adr_q   <= '0;
            valid_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        count <= count + 1'b1;
                        if (ptr != LAST_ADR) begin
                            ptr <= ptr + 1'b1;
                        end
                        if (switch_tlast || ptr == LAST_ADR) begin
                            state <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    // A reload beat takes priority and drops any same-cycle lookup.
                    if (beat) begin
                        ptr   <= ADDR_W'(1);
                        count <= (ADDR_W + 1)'(1);
                        if (!switch_tlast) begin
                            state <= ST_LOAD;
                        end
                    end else if (switch_active) begin
                        adr_q   <= mem[rd_adr];
                        valid_q <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    assign ready            = (state == ST_READY);
    assign switch_adr       = adr_q;
    assign switch_adr_valid = valid_q;
    assign load_count       = count;

endmodule

`default_nettype wire

// File: tb/tb_switch_table_mc.sv
// tb_switch_table_mc: directed checks of load, lookup, reset and (optionally) reload behaviour.
`default_nettype none

module tb_switch_table_mc;

    logic        clk;
    logic        rst;
    logic [7:0]  switch_tdata;
    logic        switch_tvalid;
    logic        switch_tlast;
    logic        switch_tready;
    logic [1:0]  jadr;
    logic [7:0]  switch_offset_adr;
    logic        switch_active;
    logic        ready;
    logic [7:0]  switch_adr;
    logic        switch_adr_valid;
    logic [10:0] load_count;

    int n_checks = 0;
    int n_fail   = 0;

    switch_table_mc dut (
        .clk               (clk),
        .rst               (rst),
        .switch_tdata      (switch_tdata),
        .switch_tvalid     (switch_tvalid),
        .switch_tlast      (switch_tlast),
        .switch_tready     (switch_tready),
        .jadr              (jadr),
        .switch_offset_adr (switch_offset_adr),
        .switch_active     (switch_active),
        .ready             (ready),
        .switch_adr        (switch_adr),
        .switch_adr_valid  (switch_adr_valid),
        .load_count        (load_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [1:0] t, input logic [7:0] o,
                          input logic [7:0] exp);
        jadr              = t;
        switch_offset_adr = o;
        switch_active     = 1'b1;
        @(negedge clk);
        switch_active     = 1'b0;
        chk({tag, "_valid"}, 16'(switch_adr_valid), 16'd1);
        chk({tag, "_adr"}, 16'(switch_adr), 16'(exp));
    endtask

    initial begin
        rst = 1'b1;
        switch_tdata = '0;
        switch_tvalid = 1'b0;
        switch_tlast = 1'b0;
        jadr = '0;
        switch_offset_adr = '0;
        switch_active = 1'b0;

        // Reset state
        @(negedge clk);
        chk("tready_in_reset", 16'(switch_tready), 16'd0);
        @(negedge clk);
        chk("rst_ready", 16'(ready), 16'd0);
        chk("rst_valid", 16'(switch_adr_valid), 16'd0);
        chk("rst_adr", 16'(switch_adr), 16'd0);
        chk("rst_load_count", 16'(load_count), 16'd0);
        rst = 1'b0;
        #1;
        chk("tready_load", 16'(switch_tready), 16'd1);

        // Full load of 1024 beats, no tlast
        for (int i = 0; i < 1024; i++) begin
            switch_tvalid = 1'b1;
            switch_tdata  = 8'(i);
            @(negedge clk);
            if (i == 1022) begin
                chk("full_ready_before_last", 16'(ready), 16'd0);
                chk("full_count_before_last", 16'(load_count), 16'd1023);
            end
        end
        switch_tvalid = 1'b0;
        chk("full_ready", 16'(ready), 16'd1);
        chk("full_load_count", 16'(load_count), 16'd1024);
        chk("full_tready", 16'(switch_tready), 16'd0);

        // Single lookup and its trailing idle cycle
        lookup("lk_2_5", 2'd2, 8'd5, 8'h05);
        @(negedge clk);
        chk("lk_idle_valid", 16'(switch_adr_valid), 16'd0);
        chk("lk_idle_adr", 16'(switch_adr), 16'd0);

        // Back-to-back lookups in READY
        jadr = 2'd3;
        switch_active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            switch_offset_adr = 8'(8'h40 + i);
            @(negedge clk);
            chk("b2b_valid", 16'(switch_adr_valid), 16'd1);
            chk("b2b_adr", 16'(switch_adr), 16'(8'h40 + i));
        end
        switch_active = 1'b0;
        @(negedge clk);
        chk("b2b_end_valid", 16'(switch_adr_valid), 16'd0);

`ifndef SWITCH_RELOAD_EN
        // Beat offered in READY must be ignored
        switch_tvalid = 1'b1;
        switch_tdata  = 8'hFF;
        switch_tlast  = 1'b1;
        @(negedge clk);
        switch_tvalid = 1'b0;
        switch_tlast  = 1'b0;
        chk("ready_beat_count", 16'(load_count), 16'd1024);
        chk("ready_beat_ready", 16'(ready), 16'd1);
        lookup("ready_beat_mem0", 2'd0, 8'd0, 8'h00);
`endif

        // Reset with a lookup in flight
        jadr = 2'd1;
        switch_offset_adr = 8'd7;
        switch_active = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        switch_active = 1'b0;
        chk("rst_inflight_valid", 16'(switch_adr_valid), 16'd0);
        chk("rst_inflight_adr", 16'(switch_adr), 16'd0);
        chk("rst_inflight_ready", 16'(ready), 16'd0);

        // Ten beats with lookups requested during LOAD, then reset mid-load
        jadr = 2'd0;
        for (int i = 0; i < 10; i++) begin
            switch_tvalid = 1'b1;
            switch_tdata  = 8'(8'h50 + i);
            switch_active = 1'b1;
            switch_offset_adr = 8'(i % 3);
            @(negedge clk);
            chk("load_lookup_valid", 16'(switch_adr_valid), 16'd0);
        end
        switch_tvalid = 1'b0;
        switch_active = 1'b0;
        chk("mid_count", 16'(load_count), 16'd10);
        chk("mid_ready", 16'(ready), 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_count", 16'(load_count), 16'd0);
        chk("midrst_ready", 16'(ready), 16'd0);

        // Short load with tlast on beat 4
        for (int i = 0; i < 4; i++) begin
            switch_tvalid = 1'b1;
            switch_tdata  = 8'(8'hA0 + i);
            switch_tlast  = (i == 3);
            @(negedge clk);
        end
        switch_tvalid = 1'b0;
        switch_tlast  = 1'b0;
        chk("short_ready", 16'(ready), 16'd1);
        chk("short_count", 16'(load_count), 16'd4);
        lookup("short_0_3", 2'd0, 8'd3, 8'hA3);
        lookup("short_0_5_kept", 2'd0, 8'd5, 8'h55);
        lookup("short_1_2_kept", 2'd1, 8'd2, 8'h02);
        lookup("short_3_255", 2'd3, 8'd255, 8'hFF);

`ifdef SWITCH_RELOAD_EN
        // Single-beat reload with a simultaneous lookup
        chk("reload_tready", 16'(switch_tready), 16'd1);
        switch_tvalid = 1'b1;
        switch_tdata  = 8'h7E;
        switch_tlast  = 1'b1;
        jadr = 2'd1;
        switch_offset_adr = 8'd2;
        switch_active = 1'b1;
        @(negedge clk);
        switch_tvalid = 1'b0;
        switch_tlast  = 1'b0;
        switch_active = 1'b0;
        chk("reload_drop_valid", 16'(switch_adr_valid), 16'd0);
        chk("reload_ready", 16'(ready), 16'd1);
        chk("reload_count", 16'(load_count), 16'd1);
        lookup("reload_0_0", 2'd0, 8'd0, 8'h7E);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
